// File: rtl/chip8_draw_sequencer.sv
// chip8_draw_sequencer: sequences CLEAR and DRAW commands for a 64x32
// CHIP-8 framebuffer. It fetches sprite bytes one row at a time, does a
// read-modify-write XOR of each framebuffer row, and reports pixel collisions.
module chip8_draw_sequencer #(
    parameter int CLIP_Y = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic        cmd_op,
    input  logic [5:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [3:0]  cmd_n,
    output logic        cmd_ready,
    output logic        spr_rd_req,
    output logic [3:0]  spr_idx,
    input  logic        spr_rd_valid,
    input  logic [7:0]  spr_data,
    output logic [4:0]  fb_addr,
    input  logic [63:0] fb_rdata,
    output logic [63:0] fb_wdata,
    output logic        fb_we,
    output logic        busy,
    output logic        done,
    output logic        collision
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RD    = 3'd4;
    localparam logic [2:0] ST_WR    = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [3:0]  n_q;
    logic [3:0]  idx_q;
    logic [4:0]  row_cnt;
    logic [7:0]  spr_q;
    logic        collision_q;

    logic [5:0]  row_sum;
    logic [4:0]  row_addr;
    logic        row_skip;
    logic        last_row;
    logic [63:0] mask;

    // Places sprite byte bit 7 at column col0 and walks right, wrapping at 64.
    function automatic logic [63:0] sprite_mask(input logic [5:0] col0, input logic [7:0] bits);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            m[col0 + 6'(k)] = bits[3'(7 - k)];
        end
        return m;
    endfunction

    // The 6-bit sum keeps the carry so clipping can see rows past 31.
    assign row_sum  = {1'b0, y_q} + {2'b00, idx_q};
    assign row_addr = row_sum[4:0];
    assign row_skip = (CLIP_Y != 0) && row_sum[5];
    assign last_row = (idx_q + 4'd1) == n_q;
    assign mask     = sprite_mask(x_q, spr_q);

    // Next-state selection for the command sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_op) begin
                        state_nxt = ST_CLR;
                    end else if (cmd_n == 4'd0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_CLR: begin
                if (row_cnt == 5'd31) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_FETCH: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (spr_rd_valid) begin
                    if (row_skip) begin
                        state_nxt = last_row ? ST_DONE : ST_FETCH;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_RD:   state_nxt = ST_WR;
            ST_WR:   state_nxt = last_row ? ST_DONE : ST_FETCH;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts whatever command is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latches, row/clear counters, sprite byte and sticky collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            row_cnt     <= '0;
            spr_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        x_q         <= cmd_x;
                        y_q         <= cmd_y;
                        n_q         <= cmd_n;
                        idx_q       <= '0;
                        row_cnt     <= '0;
                        collision_q <= 1'b0;
                    end
                end
                ST_CLR: begin
                    row_cnt <= row_cnt + 5'd1;
                end
                ST_WAIT: begin
                    if (spr_rd_valid) begin
                        spr_q <= spr_data;
                        if (row_skip) begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                ST_WR: begin
                    if (|(fb_rdata & mask)) begin
                        collision_q <= 1'b1;
                    end
                    idx_q <= idx_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Memory-side strobes are decoded purely from the current state.
    always_comb begin
        spr_rd_req = 1'b0;
        fb_we      = 1'b0;
        fb_addr    = '0;
        fb_wdata   = '0;
        case (state)
            ST_CLR: begin
                fb_we   = 1'b1;
                fb_addr = row_cnt;
            end
            ST_FETCH: begin
                spr_rd_req = 1'b1;
            end
            ST_RD: begin
                fb_addr = row_addr;
            end
            ST_WR: begin
                fb_we    = 1'b1;
                fb_addr  = row_addr;
                fb_wdata = fb_rdata ^ mask;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = (state == ST_DONE);
    assign spr_idx   = idx_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_chip8_draw_sequencer.sv
// tb_chip8_draw_sequencer: runs a clipping (CLIP_Y=1) and a wrapping (CLIP_Y=0)
// sequencer side by side against a pixel-level framebuffer model.
module tb_chip8_draw_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_op;
    logic [5:0]  cmd_x;
    logic [4:0]  cmd_y;
    logic [3:0]  cmd_n;

    logic        cmd_ready    [2];
    logic        spr_rd_req   [2];
    logic [3:0]  spr_idx      [2];
    logic        spr_rd_valid [2];
    logic [7:0]  spr_data     [2];
    logic [4:0]  fb_addr      [2];
    logic [63:0] fb_rdata     [2];
    logic [63:0] fb_wdata     [2];
    logic        fb_we        [2];
    logic        busy         [2];
    logic        done         [2];
    logic        collision    [2];

    // Instance 0 clips rows below 31, instance 1 wraps them.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        chip8_draw_sequencer #(.CLIP_Y(g == 0 ? 1 : 0)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .cmd_valid   (cmd_valid),
            .cmd_op      (cmd_op),
            .cmd_x       (cmd_x),
            .cmd_y       (cmd_y),
            .cmd_n       (cmd_n),
            .cmd_ready   (cmd_ready[g]),
            .spr_rd_req  (spr_rd_req[g]),
            .spr_idx     (spr_idx[g]),
            .spr_rd_valid(spr_rd_valid[g]),
            .spr_data    (spr_data[g]),
            .fb_addr     (fb_addr[g]),
            .fb_rdata    (fb_rdata[g]),
            .fb_wdata    (fb_wdata[g]),
            .fb_we       (fb_we[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .collision   (collision[g])
        );
    end

    logic [7:0]  spr_rom [16];
    logic [63:0] fb_mem  [2][32];
    logic [63:0] ref_fb  [2][32];
    logic        preload_req;
    logic [63:0] preload_val;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    logic [4:0]  exp_wr_addr [2][1024];
    logic [63:0] exp_wr_data [2][1024];
    logic [3:0]  exp_rq_idx  [2][1024];
    int          exp_wr_cnt [2] = '{0, 0};
    int          exp_rq_cnt [2] = '{0, 0};
    int          wr_ptr     [2] = '{0, 0};
    int          rq_ptr     [2] = '{0, 0};
    int          done_total [2] = '{0, 0};
    int          done_cnt   [2] = '{0, 0};
    int          exp_done_cyc  [2];
    int          last_done_cyc [2];
    int          exp_lat [2];
    bit          exp_col [2];
    int          wr_base [2];
    int          rq_base [2];
    int          last_acc;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Sprite memory with one-cycle latency and registered-read framebuffer.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            spr_rd_valid[g] <= spr_rd_req[g];
            spr_data[g]     <= spr_rom[spr_idx[g]];
            fb_rdata[g]     <= fb_mem[g][fb_addr[g]];
            if (preload_req) begin
                for (int r = 0; r < 32; r++) fb_mem[g][r] <= preload_val;
            end else if (fb_we[g]) begin
                fb_mem[g][fb_addr[g]] <= fb_wdata[g];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Compare process: every write, sprite request and done pulse against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < 2; g++) begin
                checkOutput($sformatf("busy_vs_ready_%0d", g), 64'(busy[g]), 64'(!cmd_ready[g]));
                if (cmd_ready[g] || done[g])
                    checkOutput($sformatf("quiet_idle_done_%0d", g), 64'({fb_we[g], spr_rd_req[g]}), 64'd0);
                if (fb_we[g] || spr_rd_req[g])
                    checkOutput($sformatf("we_req_excl_%0d", g), 64'(fb_we[g] & spr_rd_req[g]), 64'd0);
                if (fb_we[g]) begin
                    if (wr_ptr[g] < exp_wr_cnt[g]) begin
                        checkOutput($sformatf("wr_addr_%0d_%0d", g, wr_ptr[g]), 64'(fb_addr[g]), 64'(exp_wr_addr[g][wr_ptr[g]]));
                        checkOutput($sformatf("wr_data_%0d_%0d", g, wr_ptr[g]), fb_wdata[g], exp_wr_data[g][wr_ptr[g]]);
                    end else begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write_%0d: got row %0d expected no write", g, fb_addr[g]);
                    end
                    wr_ptr[g]++;
                end
                if (spr_rd_req[g]) begin
                    if (rq_ptr[g] < exp_rq_cnt[g]) begin
                        checkOutput($sformatf("spr_idx_%0d_%0d", g, rq_ptr[g]), 64'(spr_idx[g]), 64'(exp_rq_idx[g][rq_ptr[g]]));
                    end else begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_req_%0d: got idx %0d expected no request", g, spr_idx[g]);
                    end
                    rq_ptr[g]++;
                end
                if (done[g]) begin
                    last_done_cyc[g] = cyc;
                    if (done_cnt[g] < done_total[g]) begin
                        checkOutput($sformatf("done_cycle_%0d", g), 64'(cyc), 64'(exp_done_cyc[g]));
                    end else begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done_%0d: got done at %0d expected none", g, cyc);
                    end
                    done_cnt[g]++;
                end
            end
        end
    end

    // Pixel-level model: XOR sprite pixels into the expected framebuffer.
    task automatic modelCommand(input logic op, input int x, input int y, input int n, input int abort_row);
        logic [63:0] m;
        int          r;
        int          lat;
        bit          col;
        bit          clip;
        for (int g = 0; g < 2; g++) begin
            clip = (g == 0);
            col  = 1'b0;
            wr_base[g] = exp_wr_cnt[g];
            rq_base[g] = exp_rq_cnt[g];
            if (!op) begin
                lat = 33;
                for (int row = 0; row < 32; row++) begin
                    ref_fb[g][row] = '0;
                    exp_wr_addr[g][exp_wr_cnt[g]] = 5'(row);
                    exp_wr_data[g][exp_wr_cnt[g]] = '0;
                    exp_wr_cnt[g]++;
                end
            end else begin
                lat = 1;
                for (int i = 0; i < n; i++) begin
                    if (abort_row >= 0 && i > abort_row) break;
                    exp_rq_idx[g][exp_rq_cnt[g]] = 4'(i);
                    exp_rq_cnt[g]++;
                    if (abort_row >= 0 && i == abort_row) break;
                    if (clip && (y + i) > 31) begin
                        lat += 2;
                        continue;
                    end
                    r = (y + i) % 32;
                    m = '0;
                    for (int k = 0; k < 8; k++) m[(x + k) % 64] = spr_rom[i][7 - k];
                    if ((ref_fb[g][r] & m) != 64'd0) col = 1'b1;
                    ref_fb[g][r] = ref_fb[g][r] ^ m;
                    exp_wr_addr[g][exp_wr_cnt[g]] = 5'(r);
                    exp_wr_data[g][exp_wr_cnt[g]] = ref_fb[g][r];
                    exp_wr_cnt[g]++;
                    lat += 4;
                end
            end
            exp_col[g] = col;
            exp_lat[g] = lat;
        end
    endtask

    task automatic waitReady();
        int guard = 0;
        @(negedge clk);
        while (!(cmd_ready[0] && cmd_ready[1]) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: got busy expected cmd_ready");
        end
    endtask

    task automatic compareFb(input string tag);
        for (int g = 0; g < 2; g++) begin
            for (int r = 0; r < 32; r++)
                checkOutput($sformatf("%s_fb_%0d_row%0d", tag, g, r), fb_mem[g][r], ref_fb[g][r]);
            checkOutput($sformatf("%s_all_writes_%0d", tag, g), 64'(wr_ptr[g]), 64'(exp_wr_cnt[g]));
            checkOutput($sformatf("%s_all_reqs_%0d", tag, g), 64'(rq_ptr[g]), 64'(exp_rq_cnt[g]));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic op, input int x, input int y, input int n, input bit hold);
        int guard = 0;
        waitReady();
        modelCommand(op, x, y, n, -1);
        last_acc = cyc;
        for (int g = 0; g < 2; g++) begin
            exp_done_cyc[g] = cyc + exp_lat[g];
            done_total[g]++;
        end
        cmd_op    = op;
        cmd_x     = 6'(x);
        cmd_y     = 5'(y);
        cmd_n     = 4'(n);
        cmd_valid = 1'b1;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        while (!(done_cnt[0] == done_total[0] && done_cnt[1] == done_total[1]) && guard < 300) begin
            if (hold && (done[0] || done[1])) cmd_valid = 1'b0;
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b0;
        if (guard >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_done_timeout: got no done expected done", tag);
        end
        for (int g = 0; g < 2; g++)
            checkOutput($sformatf("%s_collision_%0d", tag, g), 64'(collision[g]), 64'(exp_col[g]));
        compareFb(tag);
    endtask

    task automatic checkResetState(input string tag);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("%s_flags_%0d", tag, g),
                        64'({cmd_ready[g], busy[g], done[g], fb_we[g], spr_rd_req[g], collision[g]}), 64'b100000);
            checkOutput($sformatf("%s_fb_addr_%0d", tag, g), 64'(fb_addr[g]), 64'd0);
            checkOutput($sformatf("%s_fb_wdata_%0d", tag, g), fb_wdata[g], 64'd0);
            checkOutput($sformatf("%s_spr_idx_%0d", tag, g), 64'(spr_idx[g]), 64'd0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 1'b0;
        cmd_x       = '0;
        cmd_y       = '0;
        cmd_n       = '0;
        preload_req = 1'b0;
        preload_val = '0;
        for (int i = 0; i < 16; i++) spr_rom[i] = '0;
        repeat (3) @(negedge clk);
        checkResetState("por");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Fill the framebuffer with ones, then CLEAR it.
        preload_val = '1;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        for (int g = 0; g < 2; g++) for (int r = 0; r < 32; r++) ref_fb[g][r] = '1;
        applyStimulus("clear", 1'b0, 0, 0, 0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("clear_writes_%0d", g), 64'(wr_ptr[g] - wr_base[g]), 64'd32);
            checkOutput($sformatf("clear_latency_%0d", g), 64'(last_done_cyc[g] - last_acc), 64'd33);
            checkOutput($sformatf("clear_row31_%0d", g), fb_mem[g][31], 64'd0);
        end

        // Same 0xF0 sprite twice at the origin: draw, then erase with collision.
        spr_rom[0] = 8'hF0;
        applyStimulus("f0_first", 1'b1, 0, 0, 1, 1'b0);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("f0_first_row0_%0d", g), fb_mem[g][0], 64'h0000_0000_0000_000F);
            checkOutput($sformatf("f0_first_latency_%0d", g), 64'(last_done_cyc[g] - last_acc), 64'd5);
        end
        applyStimulus("f0_second", 1'b1, 0, 0, 1, 1'b0);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("f0_second_row0_%0d", g), fb_mem[g][0], 64'd0);
            checkOutput($sformatf("f0_second_coll_%0d", g), 64'(collision[g]), 64'd1);
        end

        // Zero-height DRAW: immediate done and clears the previous collision.
        applyStimulus("n0", 1'b1, 7, 3, 0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("n0_latency_%0d", g), 64'(last_done_cyc[g] - last_acc), 64'd1);
            checkOutput($sformatf("n0_reqs_%0d", g), 64'(rq_ptr[g] - rq_base[g]), 64'd0);
            checkOutput($sformatf("n0_coll_%0d", g), 64'(collision[g]), 64'd0);
        end

        // Horizontal wrap from column 62.
        spr_rom[0] = 8'hFF;
        applyStimulus("hwrap", 1'b1, 62, 5, 1, 1'b0);
        for (int g = 0; g < 2; g++)
            checkOutput($sformatf("hwrap_row5_%0d", g), fb_mem[g][5], 64'hC000_0000_0000_003F);

        // Bottom edge: clip versus vertical wrap.
        spr_rom[0] = 8'h81;
        spr_rom[1] = 8'h42;
        spr_rom[2] = 8'h24;
        spr_rom[3] = 8'h18;
        applyStimulus("vedge", 1'b1, 10, 30, 4, 1'b0);
        checkOutput("vedge_writes_clip", 64'(wr_ptr[0] - wr_base[0]), 64'd2);
        checkOutput("vedge_writes_wrap", 64'(wr_ptr[1] - wr_base[1]), 64'd4);
        checkOutput("vedge_reqs_clip", 64'(rq_ptr[0] - rq_base[0]), 64'd4);
        checkOutput("vedge_reqs_wrap", 64'(rq_ptr[1] - rq_base[1]), 64'd4);
        checkOutput("vedge_latency_clip", 64'(last_done_cyc[0] - last_acc), 64'd13);
        checkOutput("vedge_latency_wrap", 64'(last_done_cyc[1] - last_acc), 64'd17);
        checkOutput("vedge_row30_clip", fb_mem[0][30], 64'h0000_0000_0002_0400);
        checkOutput("vedge_row0_clip", fb_mem[0][0], 64'd0);
        checkOutput("vedge_row0_wrap", fb_mem[1][0], 64'h0000_0000_0000_9000);

        // cmd_valid held through a busy DRAW: exactly one execution.
        spr_rom[0] = 8'hAA;
        spr_rom[1] = 8'h55;
        spr_rom[2] = 8'hFF;
        applyStimulus("hold", 1'b1, 20, 8, 3, 1'b1);
        repeat (20) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("hold_writes_%0d", g), 64'(wr_ptr[g] - wr_base[g]), 64'd3);
            checkOutput($sformatf("hold_dones_%0d", g), 64'(done_cnt[g]), 64'(done_total[g]));
        end

        // A few random sprites and positions.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) spr_rom[i] = 8'($urandom_range(0, 255));
            applyStimulus($sformatf("rand%0d", t), 1'b1, int'($urandom_range(0, 63)),
                          int'($urandom_range(0, 31)), int'($urandom_range(1, 8)), 1'b0);
        end

        // Reset during row 2 of a five-row DRAW.
        for (int i = 0; i < 16; i++) spr_rom[i] = 8'h3C;
        waitReady();
        modelCommand(1'b1, 3, 0, 5, 2);
        last_acc  = cyc;
        cmd_op    = 1'b1;
        cmd_x     = 6'd3;
        cmd_y     = 5'd0;
        cmd_n     = 4'd5;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int guard = 0; guard < 50 && cyc < last_acc + 10; guard++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetState("abort");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("abort_writes_%0d", g), 64'(wr_ptr[g] - wr_base[g]), 64'd2);
            checkOutput($sformatf("abort_reqs_%0d", g), 64'(rq_ptr[g] - rq_base[g]), 64'd3);
        end
        compareFb("abort");

        applyStimulus("clear2", 1'b0, 0, 0, 0, 1'b0);
        for (int g = 0; g < 2; g++)
            checkOutput($sformatf("clear2_latency_%0d", g), 64'(last_done_cyc[g] - last_acc), 64'd33);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/chip8_draw_sequencer.md
CHIP8_DRAW_SEQUENCER -- requirements
Module: chip8_draw_sequencer

Interface
REQ-001 The block SHALL have one parameter: CLIP_Y, default 1, where 1 clips sprite rows below row 31 and 0 wraps them modulo 32.
REQ-002 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  command strobe; sampled only while cmd_ready=1.
REQ-005 cmd_op  in  1  0=CLEAR, 1=DRAW.
REQ-006 cmd_x  in  6  DRAW start column; cmd_y  in  5  DRAW start row; cmd_n  in  4  DRAW sprite height in rows.
REQ-007 cmd_ready  out  1  high only in IDLE.
REQ-008 spr_rd_req  out  1  one-cycle request for sprite byte spr_idx  out  4.
REQ-009 spr_rd_valid  in  1  and spr_data  in  8  carry the returned sprite byte (bit 7 = leftmost pixel).
REQ-010 fb_addr  out  5  framebuffer row address; fb_rdata  in  64  row data; fb_wdata  out  64; fb_we  out  1. Bit c of a row SHALL be column c.
REQ-011 busy  out  1  = ~cmd_ready; done  out  1  one-cycle completion pulse; collision  out  1  result of the last DRAW.

Function
REQ-012 States SHALL be IDLE, CLR, FETCH, WAIT, RD, WR, DONE.
REQ-013 In IDLE, cmd_valid=1 SHALL latch x, y, n and op, clear collision, and move to CLR for CLEAR, DONE for DRAW with n=0, or FETCH otherwise.
REQ-014 CLR SHALL assert fb_we=1 with fb_wdata=0 and fb_addr=row counter for rows 0..31, one row per cycle (32 cycles), then go to DONE.
REQ-015 FETCH SHALL assert spr_rd_req=1 with spr_idx=i for exactly one cycle, then go to WAIT.
REQ-016 WAIT SHALL hold until spr_rd_valid=1 and latch spr_data; a spr_rd_valid in any other state SHALL be ignored.
REQ-017 Target row SHALL be r=(y+i) mod 32 when CLIP_Y=0; when CLIP_Y=1 and y+i>31 the row SHALL be skipped, with no fb access, and i SHALL advance.
REQ-018 RD SHALL drive fb_addr=r for one cycle; fb_rdata SHALL be treated as valid in the following (WR) cycle.
REQ-019 In WR: mask bit ((x+k) mod 64) = byte bit (7-k) for k=0..7, so columns wrap horizontally.
REQ-020 In WR: fb_wdata=fb_rdata XOR mask, fb_addr=r, fb_we=1.
REQ-021 In WR: collision SHALL be set if any bit of (fb_rdata AND mask) is 1; it is sticky for the command.
REQ-022 After WR or a skipped row, i SHALL increment; if i+1=n go to DONE, else go to FETCH.
REQ-023 Minimum DRAW latency with 1-cycle sprite latency SHALL be 4 cycles per row plus 1 DONE cycle.
REQ-024 DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-025 collision SHALL hold its value until the next command is accepted; a CLEAR SHALL leave it 0.
REQ-026 fb_we and spr_rd_req SHALL never be asserted in IDLE or DONE, and SHALL never both be high in one cycle.
REQ-027 cmd_valid while busy SHALL be ignored, and no command SHALL be queued.

Reset
REQ-028 While reset=1 at a clk edge, state SHALL become IDLE and i, row counter and collision SHALL become 0.
REQ-029 From the cycle after that edge: cmd_ready=1, busy=0, done=0, fb_we=0, spr_rd_req=0, fb_addr=0, fb_wdata=0, spr_idx=0.
REQ-030 Reset mid-CLEAR or mid-DRAW SHALL abort the operation with no further fb writes and no done pulse.

Verification
REQ-031 CLEAR on fb pre-filled with ones -> 32 consecutive fb_we cycles, rows 0..31 written 0, done at cycle 33, collision=0.
REQ-032 DRAW x=0,y=0,n=1, byte 0xF0, row 0 =0 -> row 0 bits 0..3 set, collision=0; repeat the same DRAW -> row 0 =0, collision=1.
REQ-033 DRAW x=62,y=5,n=1, byte 0xFF -> row 5 bits 62,63,0..5 set (horizontal wrap).
REQ-034 DRAW y=30,n=4: CLIP_Y=1 -> only rows 30,31 written, 4 spr_rd_req pulses; CLIP_Y=0 -> rows 30,31,0,1 written.
REQ-035 DRAW n=0 -> done one cycle after acceptance, no spr_rd_req, no fb_we, collision=0; cmd_valid held high during a busy DRAW -> exactly one command executed.
REQ-036 reset asserted during row 2 of a DRAW n=5 -> next cycle IDLE, fb_we=0, no done pulse, and a following CLEAR completes normally.
